// File: rtl/lml_pkg.sv
// ============================================================================
// Module   : lml_pkg
// Brief    : Opcode encodings and queue sizing shared by the LML execution unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lml_pkg;

  localparam int OP_W        = 4;
  localparam int QUEUE_DEPTH = 2;

  localparam logic [OP_W-1:0] OP_MOVE   = 4'd0;
  localparam logic [OP_W-1:0] OP_LOAD   = 4'd1;
  localparam logic [OP_W-1:0] OP_LOADHI = 4'd2;
  localparam logic [OP_W-1:0] OP_AND    = 4'd3;
  localparam logic [OP_W-1:0] OP_OR     = 4'd4;
  localparam logic [OP_W-1:0] OP_XOR    = 4'd5;
  localparam logic [OP_W-1:0] OP_NOT    = 4'd6;
  localparam logic [OP_W-1:0] OP_NAND   = 4'd7;
  localparam logic [OP_W-1:0] OP_NOR    = 4'd8;
  localparam logic [OP_W-1:0] OP_XNOR   = 4'd9;

  // Everything above the last defined opcode is reserved.
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op <= OP_XNOR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lml_logic_core.sv
// ============================================================================
// Module   : lml_logic_core
// Brief    : Combinational load/move/logic result selector with illegal-op flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lml_logic_core
  import lml_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] value,
  output logic             err
);

  localparam int c_HALF = WIDTH / 2;

  always_comb begin
    value = '0;
    err   = !op_is_legal(op);
    case (op)
      OP_MOVE:   value = a;
      OP_LOAD:   value = b;
      OP_LOADHI: value = {b[c_HALF-1:0], a[c_HALF-1:0]};
      OP_AND:    value = a & b;
      OP_OR:     value = a | b;
      OP_XOR:    value = a ^ b;
      OP_NOT:    value = ~a;
      OP_NAND:   value = ~(a & b);
      OP_NOR:    value = ~(a | b);
      OP_XNOR:   value = ~(a ^ b);
      default:   value = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lml_exec_unit.sv
// ============================================================================
// Module   : lml_exec_unit
// Brief    : Pipelined LML execution unit with a 2-entry result queue and
//            saturating retired-op counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lml_exec_unit
  import lml_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  logic [WIDTH-1:0] w_value;
  logic             w_err;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;

  logic [1:0]       r_count;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [CNT_W-1:0] r_op_count;
  logic [WIDTH-1:0] r_value [QUEUE_DEPTH];
  logic [TAG_W-1:0] r_tag   [QUEUE_DEPTH];
  logic             r_err   [QUEUE_DEPTH];

  lml_logic_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op    (in_op),
    .a     (in_a),
    .b     (in_b),
    .value (w_value),
    .err   (w_err)
  );

  // Ready looks only at registered occupancy so out_ready never reaches in_ready.
  assign in_ready  = (r_count < 2'(QUEUE_DEPTH)) && !rst;
  assign w_empty   = (r_count == 2'd0);
  assign out_valid = !w_empty;
  assign busy      = !w_empty;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign out_value = w_empty ? '0 : r_value[r_rd_ptr];
  assign out_tag   = w_empty ? '0 : r_tag[r_rd_ptr];
  assign out_err   = w_empty ? 1'b0 : r_err[r_rd_ptr];
  assign op_count  = r_op_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_op_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_pop && (r_op_count != '1)) r_op_count <= r_op_count + 1'b1;
    end
  end

  // Payload storage needs no reset: reads are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_value[r_wr_ptr] <= w_value;
      r_tag[r_wr_ptr]   <= in_tag;
      r_err[r_wr_ptr]   <= w_err;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lml_exec_unit.sv
// ============================================================================
// Module   : tb_lml_exec_unit
// Brief    : Self-checking bench for lml_exec_unit against a queue-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lml_exec_unit;

  localparam int W = 32;
  localparam int T = 4;

  typedef struct {
    logic [31:0] value;
    logic [3:0]  tag;
    logic        err;
  } entry_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp_val;
    logic        exp_err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready, in_ready4;
  logic [3:0]    in_op;
  logic [W-1:0]  in_a, in_b;
  logic [T-1:0]  in_tag;
  logic          out_valid, out_valid4;
  logic          out_ready;
  logic [W-1:0]  out_value, out_value4;
  logic [T-1:0]  out_tag, out_tag4;
  logic          out_err, out_err4;
  logic          busy, busy4;
  logic [15:0]   op_count;
  logic [3:0]    op_count4;

  int total = 0;
  int bad   = 0;

  entry_t model_q[$];
  int     model_pops = 0;

  always #5 clk = ~clk;

  lml_exec_unit #(.WIDTH(W), .TAG_W(T), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_tag(out_tag), .out_err(out_err), .busy(busy), .op_count(op_count)
  );

  lml_exec_unit #(.WIDTH(W), .TAG_W(T), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid4), .out_ready(out_ready), .out_value(out_value4),
    .out_tag(out_tag4), .out_err(out_err4), .busy(busy4), .op_count(op_count4)
  );

  function automatic entry_t ref_result(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [3:0] tag);
    entry_t e;
    e.tag = tag;
    e.err = 1'b0;
    case (op)
      4'd0: e.value = a;
      4'd1: e.value = b;
      4'd2: e.value = {b[15:0], a[15:0]};
      4'd3: e.value = a & b;
      4'd4: e.value = a | b;
      4'd5: e.value = a ^ b;
      4'd6: e.value = ~a;
      4'd7: e.value = ~(a & b);
      4'd8: e.value = ~(a | b);
      4'd9: e.value = ~(a ^ b);
      default: begin e.value = 32'h0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive, check against the model, take the edge, advance the model.
  task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] tag,
                      input logic ordy, input logic r, output logic fired);
    entry_t head;
    logic   exp_rdy, do_push, do_pop;
    int     sat16, sat4;
    rst = r; in_valid = v; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = ordy;
    #1;
    exp_rdy = (model_q.size() < 2) && !r;
    head.value = 32'h0; head.tag = 4'h0; head.err = 1'b0;
    if (model_q.size() != 0) head = model_q[0];
    sat16 = (model_pops > 65535) ? 65535 : model_pops;
    sat4  = (model_pops > 15) ? 15 : model_pops;
    chk("in_ready",  {63'b0, in_ready},  {63'b0, exp_rdy});
    chk("out_valid", {63'b0, out_valid}, {63'b0, model_q.size() != 0});
    chk("busy",      {63'b0, busy},      {63'b0, model_q.size() != 0});
    chk("out_value", {32'b0, out_value}, {32'b0, head.value});
    chk("out_tag",   {60'b0, out_tag},   {60'b0, head.tag});
    chk("out_err",   {63'b0, out_err},   {63'b0, head.err});
    chk("op_count",  {48'b0, op_count},  64'(sat16));
    chk("op_count4", {60'b0, op_count4}, 64'(sat4));
    do_push = v && exp_rdy;
    do_pop  = (model_q.size() != 0) && ordy && !r;
    fired   = do_push;
    @(posedge clk);
    if (r) begin
      model_q.delete();
      model_pops = 0;
    end else begin
      if (do_pop) begin
        void'(model_q.pop_front());
        model_pops++;
      end
      if (do_push) model_q.push_back(ref_result(op, a, b, tag));
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    logic f;
    step(1'b0, 4'h0, 32'h0, 32'h0, 4'h0, ordy, 1'b0, f);
  endtask

  vec_t vecs[12];

  initial begin
    logic f;
    int   guard;
    vecs[0]  = '{4'd3,  32'hF0F0_1234, 32'h0FF0_FFFF, 4'd3,  32'h00F0_1234, 1'b0};
    vecs[1]  = '{4'd2,  32'hAAAA_1111, 32'h2222_BBBB, 4'd4,  32'hBBBB_1111, 1'b0};
    vecs[2]  = '{4'd6,  32'h0000_0000, 32'h1234_5678, 4'd5,  32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6,  32'h0000_0000, 1'b1};
    vecs[4]  = '{4'd0,  32'h1234_5678, 32'h0000_0009, 4'd7,  32'h1234_5678, 1'b0};
    vecs[5]  = '{4'd1,  32'h0000_0001, 32'hCAFE_BABE, 4'd8,  32'hCAFE_BABE, 1'b0};
    vecs[6]  = '{4'd4,  32'h0F0F_0000, 32'h00F0_000F, 4'd9,  32'h0FFF_000F, 1'b0};
    vecs[7]  = '{4'd5,  32'hFFFF_0000, 32'h0F0F_0F0F, 4'd10, 32'hF0F0_0F0F, 1'b0};
    vecs[8]  = '{4'd7,  32'hFFFF_0000, 32'h0F0F_0F0F, 4'd11, 32'hF0F0_FFFF, 1'b0};
    vecs[9]  = '{4'd8,  32'h0F0F_0000, 32'h00F0_000F, 4'd12, 32'hF000_FFF0, 1'b0};
    vecs[10] = '{4'd9,  32'hFFFF_0000, 32'h0F0F_0F0F, 4'd13, 32'h0F0F_F0F0, 1'b0};
    vecs[11] = '{4'd10, 32'h1111_1111, 32'h2222_2222, 4'd14, 32'h0000_0000, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_op = 4'h0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset held, then released: ready must stay low in reset and rise right after.
    step(1'b0, 4'h0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, f);
    idle(1'b1);
    idle(1'b1);

    // Directed table, one op per cycle with the consumer always ready.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, 1'b1, 1'b0, f);
      #1;
      chk($sformatf("vec%0d_value", i), {32'b0, out_value}, {32'b0, vecs[i].exp_val});
      chk($sformatf("vec%0d_err", i),   {63'b0, out_err},   {63'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d_tag", i),   {60'b0, out_tag},   {60'b0, vecs[i].tag});
    end
    idle(1'b1);
    idle(1'b1);

    // Back-pressure: two fill the queue, the third is held until a slot frees.
    step(1'b1, 4'd0, 32'hAAAA_0005, 32'h0, 4'd5, 1'b0, 1'b0, f);
    step(1'b1, 4'd1, 32'h0, 32'hBBBB_0006, 4'd6, 1'b0, 1'b0, f);
    step(1'b1, 4'd5, 32'hCCCC_0000, 32'h0000_0007, 4'd7, 1'b0, 1'b0, f);
    chk("held_third_not_taken", {63'b0, f}, 64'd0);
    step(1'b1, 4'd5, 32'hCCCC_0000, 32'h0000_0007, 4'd7, 1'b0, 1'b0, f);
    guard = 0;
    f = 1'b0;
    while (!f && guard < 8) begin
      step(1'b1, 4'd5, 32'hCCCC_0000, 32'h0000_0007, 4'd7, 1'b1, 1'b0, f);
      guard++;
    end
    chk("third_accepted", {63'b0, f}, 64'd1);
    repeat (4) idle(1'b1);

    // Full-rate random push/pop.
    for (int i = 0; i < 100; i++)
      step(1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom, 4'($urandom), 1'b1, 1'b0, f);
    idle(1'b1);
    idle(1'b1);
    #1;
    chk("op_count4_saturated", {60'b0, op_count4}, 64'd15);
    @(negedge clk);

    // Reset while two results are queued.
    step(1'b1, 4'd3, $urandom, $urandom, 4'd1, 1'b0, 1'b0, f);
    step(1'b1, 4'd4, $urandom, $urandom, 4'd2, 1'b0, 1'b0, f);
    step(1'b0, 4'd0, 32'h0, 32'h0, 4'd0, 1'b1, 1'b1, f);
    #1;
    chk("post_rst_valid", {63'b0, out_valid}, 64'd0);
    chk("post_rst_count", {48'b0, op_count},  64'd0);
    @(negedge clk);
    repeat (3) idle(1'b1);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 300; i++)
      step(1'($urandom), 4'($urandom_range(0, 15)), $urandom, $urandom, 4'($urandom),
           1'($urandom), 1'b0, f);
    repeat (3) idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lml_exec_unit.md
Name: lml_exec_unit

Overview:
- Parametrised load/move/logic execution unit for the RFT datapath, successor to the single-cycle combinational load/move/logic selector.
- Accepts one operation per cycle over a valid/ready handshake and computes a registered result.
- Buffers results in a 2-entry output queue so downstream back-pressure does not stall issue immediately.
- Adds an illegal-op flag, result tags and a saturating retired-op counter.

Parameters:
- WIDTH, 32: datapath width in bits. Even, ≥ 8.
- TAG_W, 4: width of the issue tag carried alongside each operation.
- CNT_W, 16: width of the retired-op counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  issue request.
- in_ready  out  1  unit can accept an issue this cycle.
- in_op  in  4  opcode (see Behaviour).
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B / load data.
- in_tag  in  TAG_W  issue tag.
- out_valid  out  1  result available at queue head.
- out_ready  in  1  consumer accepts the head result.
- out_value  out  WIDTH  result value.
- out_tag  out  TAG_W  tag of the head result.
- out_err  out  1  head result came from an illegal opcode.
- busy  out  1  queue non-empty.
- op_count  out  CNT_W  saturating count of retired results.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Opcodes:
  - 0 MOVE = a
  - 1 LOAD = b
  - 2 LOADHI = {b[WIDTH/2-1:0], a[WIDTH/2-1:0]}
  - 3 AND, 4 OR, 5 XOR
  - 6 NOT = ~a
  - 7 NAND, 8 NOR, 9 XNOR
  - 10–15 are illegal: value = 0, err = 1.
- Issue handshake:
  - An issue fires when in_valid && in_ready at a rising edge.
  - in_ready = (count < 2) && !rst. It depends only on registered state; no combinational path from out_ready.
- Result path:
  - The result is computed combinationally from in_* and written into the queue on the issue edge.
  - Latency: an issue at edge N into an empty queue gives out_valid = 1 after edge N.
  - Full throughput is 1 op/cycle when out_ready is held high.
- Output queue:
  - 2-entry FIFO holding {value, tag, err}, with 1-bit read and write pointers plus a 2-bit count.
  - Pop fires when out_valid && out_ready.
  - out_* are driven from the head entry. out_value, out_tag and out_err are 0 when empty.
  - out_valid = busy = (count != 0).
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full (count = 2): in_ready = 0, so no push; a pop that cycle frees a slot for the next cycle.
  - Empty with push: entry visible the next cycle. There is no same-cycle bypass.
  - Pointers wrap modulo 2.
- op_count:
  - Increments by 1 on each pop, including pops of err entries.
  - Saturates at all-ones and does not wrap.
- Reset:
  - Values after reset: count = 0, pointers = 0, op_count = 0, out_valid = 0, out_value / out_tag / out_err = 0, busy = 0, in_ready = 0 during reset.
  - Reset mid-operation discards queued results with no pop side effects.
  - in_ready = 1 the cycle after rst deasserts.
- Inputs are ignored while in_ready = 0. A held in_valid is re-presented by the producer.

Decomposition:
- Package lml_pkg:
  - opcode localparams: OP_MOVE, OP_LOAD, OP_LOADHI, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_NAND, OP_NOR, OP_XNOR.
  - OP_W = 4.
  - QUEUE_DEPTH = 2.
- Sub-module lml_logic_core: purely combinational, parameter WIDTH.
  - Inputs: op, a, b.
  - Outputs: value, err.
- lml_exec_unit instantiates lml_logic_core and owns the queue, handshake and counter.

Test Plan:
- Reset then idle → out_valid = 0, busy = 0, op_count = 0, in_ready = 0 during rst and 1 the cycle after.
- WIDTH = 32, out_ready = 1, issue AND a = 0xF0F0_1234, b = 0x0FF0_FFFF, tag = 3 → next cycle out_value = 0x00F0_1234, out_tag = 3, out_err = 0, op_count = 1 after the pop.
- LOADHI a = 0xAAAA_1111, b = 0x2222_BBBB → out_value = 0xBBBB_1111. NOT a = 0 → 0xFFFF_FFFF.
- out_ready = 0, issue three back-to-back ops → in_ready drops after the 2nd accept, and the 3rd is held. Raise out_ready → results arrive in issue order with correct tags, the 3rd is accepted once a slot frees, and there is no loss or duplication.
- Opcode 12, a = b = 0xFFFF_FFFF → out_value = 0, out_err = 1. The next legal op has out_err = 0.
- Continuous push and pop at full rate for 100 cycles with random ops → every result matches the model, count stays at 1, and pointers wrap correctly.
- CNT_W = 4: retire 20 ops → op_count = 15 (saturated).
- Assert rst with 2 entries queued → out_valid = 0 and op_count = 0 the next cycle, and no stale results appear afterwards.
